// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   fetch_state_t    : fetch FSM state encoding
//   DEFAULT_RESET_PC : default first fetch address after reset
//   OP_*             : opcode constants used by the controller
//   sext16           : 16-to-32 bit sign extension helper
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and the decode stage.
//   imem_req/imem_addr     : read request to instruction memory (fetch -> mem)
//   imem_ack/imem_rdata    : read response (mem -> fetch)
//   instr_valid/instr/op/funct/pc/pc_plus4 : held instruction (fetch -> decode)
//   instr_ready/pcsrc/jump : consume strobe and redirect controls (decode -> fetch)
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_if;
   import mips_pkg::*;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        pcsrc;
   logic        jump;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, op, funct, pc, pc_plus4,
      input  imem_ack, imem_rdata, instr_ready, pcsrc, jump
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, op, funct, pc, pc_plus4,
      output imem_ack, imem_rdata, instr_ready, pcsrc, jump
   );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection, purely combinational.
//   pc_plus4 : address of the held instruction + 4
//   instr    : held instruction (jump target / branch offset fields)
//   pcsrc    : take branch
//   jump     : take jump, overrides pcsrc
//   next_pc  : selected next fetch address
module pc_next
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        pcsrc,
   input  logic        jump,
   output logic [31:0] next_pc
);

   logic [31:0] jump_target;
   logic [31:0] branch_target;

   // Both targets are word-aligned by construction, so next_pc[1:0] stays 0.
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign branch_target = pc_plus4 + (sext16(instr[15:0]) << 2);

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (pcsrc) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at pc, holds it for decode until
// consumed, then advances pc (sequential, branch or jump).
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : instr_fetch_if.master (memory request/response, held instruction,
//             consume strobe and redirect controls)
//
// state | meaning
// IDLE  | after reset; no request, nothing held; moves to FETCH next cycle
// FETCH | imem_req=1 at pc; waits (unbounded) for imem_ack, captures rdata
// HOLD  | instr_valid=1; waits for instr_ready, then loads next_pc
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic          clk,
   input  logic          reset_n,
   instr_fetch_if.master bus
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   fetch_state_t state;
   fetch_state_t state_nxt;

   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        req;
   logic        valid;
   logic        capture;
   logic        accept;

   assign pc_plus4 = pc_q + 32'd4;

   pc_next u_pc_next (
      .pc_plus4 (pc_plus4),
      .instr    (instr_q),
      .pcsrc    (bus.pcsrc),
      .jump     (bus.jump),
      .next_pc  (next_pc)
   );

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      valid     = 1'b0;
      capture   = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            req = 1'b1;
            if (bus.imem_ack) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            valid = 1'b1;
            if (bus.instr_ready) begin
               accept    = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         pc_q    <= RESET_PC_ALIGNED;
         instr_q <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            instr_q <= bus.imem_rdata;
         end
         if (accept) begin
            pc_q <= next_pc;
         end
      end
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = valid;
   assign bus.instr       = instr_q;
   assign bus.op          = instr_q[31:26];
   assign bus.funct       = instr_q[5:0];
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;

endmodule
